// File: rtl/sampled_dut_pkg.sv
// Shared constants for the ETS device-under-test: function codes and select field layout.
package sampled_dut_pkg;

    typedef enum logic [1:0] {
        FN_DIRECT = 2'd0,
        FN_INC    = 2'd1,
        FN_ADD    = 2'd2,
        FN_PARITY = 2'd3
    } fn_e;

    localparam int unsigned IDX_LSB  = 0;
    localparam int unsigned FN_LSB   = 5;
    localparam int unsigned FN_W     = 2;
    localparam int unsigned RSVD_LSB = 7;

endpackage

// File: rtl/sampled_dut_probe_mux.sv
// Selects one bit of one node vector; any nonzero reserved select bit forces the probe low.
module probe_mux
    import sampled_dut_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] node_direct,
    input  logic [WIDTH-1:0] node_inc,
    input  logic [WIDTH-1:0] node_add,
    input  logic [WIDTH-1:0] node_parity,
    input  logic [WIDTH-1:0] signal_select,
    output logic             probe
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0]      idx;
    logic [FN_W-1:0]       fn;
    logic [WIDTH-1:RSVD_LSB] rsvd;
    logic                  sel_bit;

    assign idx  = signal_select[IDX_LSB +: IDX_W];
    assign fn   = signal_select[FN_LSB +: FN_W];
    assign rsvd = signal_select[WIDTH-1:RSVD_LSB];

    always_comb begin
        sel_bit = 1'b0;
        case (fn)
            FN_DIRECT: sel_bit = node_direct[idx];
            FN_INC:    sel_bit = node_inc[idx];
            FN_ADD:    sel_bit = node_add[idx];
            FN_PARITY: sel_bit = node_parity[idx];
            default:   sel_bit = 1'b0;
        endcase
    end

    assign probe = (rsvd == '0) ? sel_bit : 1'b0;

endmodule

// File: rtl/sampled_dut.sv
// ETS core: registers the stimulus word and its predecessor, builds carry-chain,
// adder and prefix-parity nodes, and exposes one selected node bit unregistered.
module sampled_dut
    import sampled_dut_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dut_input,
    input  logic [WIDTH-1:0] signal_select,
    output logic             dut_output
);

    (* keep = "true" *) logic [WIDTH-1:0] in_q;
    (* keep = "true" *) logic [WIDTH-1:0] prev_q;

    (* keep = "true" *) logic [WIDTH-1:0] node_direct;
    (* keep = "true" *) logic [WIDTH-1:0] node_inc;
    (* keep = "true" *) logic [WIDTH-1:0] node_add;
    (* keep = "true" *) logic [WIDTH-1:0] node_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= in_q;
            in_q   <= dut_input;
        end
    end

    assign node_direct = in_q;
    assign node_inc    = in_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign node_add    = in_q + prev_q;

    // Each parity bit is an independent reduction so path depth tracks the bit index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_parity
        assign node_parity[i] = ^in_q[i:0];
    end

    probe_mux #(
        .WIDTH(WIDTH)
    ) u_probe_mux (
        .node_direct  (node_direct),
        .node_inc     (node_inc),
        .node_add     (node_add),
        .node_parity  (node_parity),
        .signal_select(signal_select),
        .probe        (dut_output)
    );

endmodule

// File: tb/tb_sampled_dut.sv
// Directed bench for sampled_dut with hand-computed expected probe values.
module tb_sampled_dut;

    logic        clk;
    logic        rst;
    logic [31:0] dut_input;
    logic [31:0] signal_select;
    logic        dut_output;

    int unsigned n_pass;
    int unsigned n_total;

    sampled_dut #(
        .WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dut_input    (dut_input),
        .signal_select(signal_select),
        .dut_output   (dut_output)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_sel(input logic [1:0] fn, input logic [4:0] k);
        return {25'b0, fn, k};
    endfunction

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        dut_input = v;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input logic [1:0] fn, input logic [4:0] k,
                         input logic exp);
        signal_select = mk_sel(fn, k);
        #1;
        check(tag, {31'b0, dut_output}, {31'b0, exp});
    endtask

    task automatic probe_raw(input string tag, input logic [31:0] sel, input logic exp);
        signal_select = sel;
        #1;
        check(tag, {31'b0, dut_output}, {31'b0, exp});
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        dut_input     = 32'h0;
        signal_select = 32'h0;

        // 1. reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        probe("rst_inc_k0",    2'd1, 5'd0,  1'b1);
        probe("rst_dir_k31",   2'd0, 5'd31, 1'b0);
        probe("rst_add_k0",    2'd2, 5'd0,  1'b0);
        probe("rst_par_k31",   2'd3, 5'd31, 1'b0);

        // 2. incrementer carry across 0xFF
        load(32'h0000_00FF);
        probe("ff_inc_k8",     2'd1, 5'd8,  1'b1);
        probe("ff_inc_k7",     2'd1, 5'd7,  1'b0);
        probe("ff_dir_k7",     2'd0, 5'd7,  1'b1);
        probe("ff_par_k7",     2'd3, 5'd7,  1'b0);
        probe("ff_par_k0",     2'd3, 5'd0,  1'b1);

        // 3. adder: prev=1, in=3 -> 4
        load(32'h0000_0001);
        load(32'h0000_0003);
        probe("add_1p3_k2",    2'd2, 5'd2,  1'b1);
        probe("add_1p3_k0",    2'd2, 5'd0,  1'b0);
        probe("add_1p3_k1",    2'd2, 5'd1,  1'b0);
        probe("dir_3_k1",      2'd0, 5'd1,  1'b1);

        // 4. parity on 0x7 (prev=3 -> sum 0xA), then all-ones wrap
        load(32'h0000_0007);
        probe("par7_k2",       2'd3, 5'd2,  1'b1);
        probe("par7_k1",       2'd3, 5'd1,  1'b0);
        probe("add_3p7_k1",    2'd2, 5'd1,  1'b1);
        probe("add_3p7_k3",    2'd2, 5'd3,  1'b1);
        load(32'hFFFF_FFFF);
        probe("ones_inc_k31",  2'd1, 5'd31, 1'b0);
        probe("ones_inc_k0",   2'd1, 5'd0,  1'b0);
        probe("add_wrap_k0",   2'd2, 5'd0,  1'b0);
        probe("add_wrap_k2",   2'd2, 5'd2,  1'b1);
        probe("add_wrap_k31",  2'd2, 5'd31, 1'b0);
        probe("ones_par_k31",  2'd3, 5'd31, 1'b0);
        probe("ones_par_k30",  2'd3, 5'd30, 1'b1);

        // 5. reserved-bit gating
        probe_raw("rsvd_b7",    32'h0000_0080, 1'b0);
        probe_raw("sel_1f",     32'h0000_001F, 1'b1);
        probe_raw("rsvd_b31",   32'h8000_001F, 1'b0);

        // 6. mid-stream reset clears both registers
        load(32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe("mrst_dir_k31",  2'd0, 5'd31, 1'b0);
        for (int i = 0; i < 32; i += 5) begin
            probe($sformatf("mrst_add_k%0d", i), 2'd2, 5'(i), 1'b0);
        end
        load(32'h0000_0005);
        probe("post_add_k0",   2'd2, 5'd0,  1'b1);
        probe("post_add_k1",   2'd2, 5'd1,  1'b0);
        probe("post_add_k2",   2'd2, 5'd2,  1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
